// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the cache-side request/fill signals and the shared main-memory port
// seen by cache_mem_arbiter; the master modport is the arbiter's view.
interface cache_mem_arbiter_if;
  logic        icache_req;
  logic [15:0] icache_addr;
  logic        dcache_req;
  logic [15:0] dcache_addr;
  logic        dcache_wr_req;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic        icache_data_valid;
  logic        dcache_data_valid;
  logic [15:0] fill_data;
  logic        dcache_wr_ack;
  logic        i_grant;
  logic        d_grant;

  modport master (
    input  icache_req, icache_addr, dcache_req, dcache_addr,
    input  dcache_wr_req, dcache_wr_addr, dcache_wr_data,
    input  mem_data_valid, mem_rdata,
    output mem_enable, mem_wr, mem_addr, mem_wdata,
    output icache_data_valid, dcache_data_valid, fill_data,
    output dcache_wr_ack, i_grant, d_grant
  );

  modport slave (
    output icache_req, icache_addr, dcache_req, dcache_addr,
    output dcache_wr_req, dcache_wr_addr, dcache_wr_data,
    output mem_data_valid, mem_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_wdata,
    input  icache_data_valid, dcache_data_valid, fill_data,
    input  dcache_wr_ack, i_grant, d_grant
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle main memory between I-fill, D-fill and D-side
// write-through stores; a fill issues a whole block of reads back-to-back.
module cache_mem_arbiter #(
  parameter int BEATS = 8
) (
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.master bus
);
  localparam int CW = $clog2(BEATS);
  localparam int BW = 15 - CW;

  typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] ret_cnt_q, ret_cnt_d;
  logic          done_q, done_d;
  logic          last_d_q, last_d_d;
  logic [BW-1:0] base_q, base_d;

  logic          in_fill;
  logic          mem_enable;
  logic          mem_wr;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          icache_valid;
  logic          dcache_valid;
  logic          wr_ack;
  logic          unused_addr_bits;

  // Only the block address of a miss matters; the word offset comes from issue_cnt.
  assign unused_addr_bits = ^{bus.icache_addr[15-BW:0], bus.dcache_addr[15-BW:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      done_q      <= 1'b0;
      last_d_q    <= 1'b0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      done_q      <= done_d;
      last_d_q    <= last_d_d;
      base_q      <= base_d;
    end
  end

  assign in_fill = (state_q == IFILL) || (state_q == DFILL);

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    done_d       = done_q;
    last_d_d     = last_d_q;
    base_d       = base_q;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    icache_valid = 1'b0;
    dcache_valid = 1'b0;
    wr_ack       = 1'b0;

    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        done_d      = 1'b0;
        // An I-miss starved by the previous D-side owner jumps the fixed order.
        if (last_d_q && bus.icache_req) begin
          state_d = IFILL;
          base_d  = bus.icache_addr[15 -: BW];
        end else if (bus.dcache_req) begin
          state_d = DFILL;
          base_d  = bus.dcache_addr[15 -: BW];
        end else if (bus.dcache_wr_req) begin
          state_d = DWRITE;
        end else if (bus.icache_req) begin
          state_d = IFILL;
          base_d  = bus.icache_addr[15 -: BW];
        end
      end

      IFILL, DFILL: begin
        if (!done_q) begin
          mem_enable  = 1'b1;
          mem_addr    = {base_q, issue_cnt_q, 1'b0};
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == CW'(BEATS - 1)) begin
            done_d = 1'b1;
          end
        end
        // Returns are counted even if the owner dropped its request, so the
        // memory pipeline is always drained before the next grant.
        if (bus.mem_data_valid) begin
          icache_valid = (state_q == IFILL);
          dcache_valid = (state_q == DFILL);
          ret_cnt_d    = ret_cnt_q + 1'b1;
          if (ret_cnt_q == CW'(BEATS - 1)) begin
            state_d  = IDLE;
            last_d_d = (state_q == DFILL);
          end
        end
      end

      DWRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = bus.dcache_wr_addr;
        mem_wdata  = bus.dcache_wr_data;
        wr_ack     = 1'b1;
        last_d_d   = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_enable        = mem_enable;
  assign bus.mem_wr            = mem_wr;
  assign bus.mem_addr          = mem_addr;
  assign bus.mem_wdata         = mem_wdata;
  assign bus.icache_data_valid = icache_valid;
  assign bus.dcache_data_valid = dcache_valid;
  assign bus.dcache_wr_ack     = wr_ack;
  assign bus.i_grant           = (state_q == IFILL);
  assign bus.d_grant           = (state_q == DFILL);
  // Read data is shown only while a fill owns memory, so idle/reset outputs stay 0.
  assign bus.fill_data         = in_fill ? bus.mem_rdata : 16'h0000;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: 3-cycle-latency memory model, simple
// cache fill/store requesters, and per-scenario checks of issue order and grants.
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.BEATS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: a read issued in cycle k returns its data in cycle k+3.
  bit   [2:0]  pv;
  logic [15:0] pa [3];
  always @(posedge clk) begin
    pv    <= {pv[1:0], bus.mem_enable & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
  end
  assign bus.mem_data_valid = pv[2];
  assign bus.mem_rdata      = pv[2] ? (pa[2] ^ 16'hA5A5) : 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] iss_addr[$];
  int          iss_cyc[$];
  int          seg_own[$];
  int          seg_start[$];
  int          seg_end[$];
  int          prev_own;
  int          ibeats, dbeats, bad_fill, wr_cnt, wr_cyc, ack_cnt, proto_err, stray;
  int          last_ival_cyc;
  logic [15:0] wr_addr_l, wr_data_l;
  bit          i_auto, d_auto;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
      $display("  ok   %s = %0h", tag, obs);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [63:0] outs();
    return {9'd0, bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
            bus.icache_data_valid, bus.dcache_data_valid, bus.fill_data,
            bus.dcache_wr_ack, bus.i_grant, bus.d_grant};
  endfunction

  task automatic clear_logs();
    iss_addr.delete(); iss_cyc.delete();
    seg_own.delete(); seg_start.delete(); seg_end.delete();
    prev_own = 0; ibeats = 0; dbeats = 0; bad_fill = 0; wr_cnt = 0; wr_cyc = -1;
    ack_cnt = 0; proto_err = 0; stray = 0; last_ival_cyc = -1;
    wr_addr_l = '0; wr_data_l = '0;
  endtask

  // One clock of observation plus the cache-side reaction, at the falling edge.
  task automatic step();
    int          own;
    logic [15:0] exp;
    @(negedge clk);
    cyc++;
    own = bus.d_grant ? 2 : bus.i_grant ? 1 : bus.dcache_wr_ack ? 3 : 0;
    if (own != prev_own) begin
      if (prev_own != 0) seg_end.push_back(cyc - 1);
      if (own != 0) begin
        seg_own.push_back(own);
        seg_start.push_back(cyc);
      end
      prev_own = own;
    end
    if ((bus.i_grant && bus.d_grant) ||
        (bus.icache_data_valid && !bus.i_grant) ||
        (bus.dcache_data_valid && !bus.d_grant) ||
        (bus.dcache_wr_ack != (bus.mem_enable && bus.mem_wr)) ||
        (bus.mem_enable && own == 0))
      proto_err++;
    if (bus.mem_enable && !bus.mem_wr) begin
      iss_addr.push_back(bus.mem_addr);
      iss_cyc.push_back(cyc);
    end
    if (bus.mem_enable && bus.mem_wr) begin
      wr_cnt++;
      wr_cyc    = cyc;
      wr_addr_l = bus.mem_addr;
      wr_data_l = bus.mem_wdata;
    end
    if (bus.dcache_wr_ack) begin
      ack_cnt++;
      bus.dcache_wr_req = 1'b0;
    end
    if (bus.mem_data_valid && !rst && !bus.i_grant && !bus.d_grant) stray++;
    if (bus.icache_data_valid) begin
      exp = ((bus.icache_addr & 16'hFFF0) | 16'((ibeats % 8) * 2)) ^ 16'hA5A5;
      if (bus.fill_data !== exp) bad_fill++;
      ibeats++;
      last_ival_cyc = cyc;
      if (i_auto && (ibeats % 8) == 0) bus.icache_req = 1'b0;
    end
    if (bus.dcache_data_valid) begin
      exp = ((bus.dcache_addr & 16'hFFF0) | 16'((dbeats % 8) * 2)) ^ 16'hA5A5;
      if (bus.fill_data !== exp) bad_fill++;
      dbeats++;
      if (d_auto && (dbeats % 8) == 0) bus.dcache_req = 1'b0;
    end
  endtask

  task automatic run_idle(input int maxc, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < maxc) begin
      step();
      n++;
      if (bus.icache_req || bus.dcache_req || bus.dcache_wr_req ||
          bus.i_grant || bus.d_grant || bus.mem_data_valid)
        quiet = 0;
      else
        quiet++;
    end
    chk({tag, "_settled"}, 64'(quiet >= 4), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.icache_req = 1'b0; bus.dcache_req = 1'b0; bus.dcache_wr_req = 1'b0;
    i_auto = 1'b1; d_auto = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    clear_logs();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    bus.icache_req = 1'b0; bus.icache_addr = '0;
    bus.dcache_req = 1'b0; bus.dcache_addr = '0;
    bus.dcache_wr_req = 1'b0; bus.dcache_wr_addr = '0; bus.dcache_wr_data = '0;
    i_auto = 1'b1; d_auto = 1'b1;
    clear_logs();

    // Reset state
    step(); step();
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_outs", outs(), 64'd0);
    clear_logs();

    // Single I-miss at 0x1234
    bus.icache_addr = 16'h1234; bus.icache_req = 1'b1; c0 = cyc;
    run_idle(60, "t1");
    chk("t1_n_issue", iss_addr.size(), 8);
    for (int i = 0; i < iss_addr.size() && i < 8; i++)
      chk($sformatf("t1_addr%0d", i), iss_addr[i], 64'(16'h1230 + 16'(2 * i)));
    chk("t1_issue_span", qget(iss_cyc, 7) - qget(iss_cyc, 0), 7);
    chk("t1_segs", seg_own.size(), 1);
    chk("t1_owner", qget(seg_own, 0), 1);
    chk("t1_grant_lat", qget(seg_start, 0), c0 + 1);
    chk("t1_first_issue", qget(iss_cyc, 0), qget(seg_start, 0));
    chk("t1_hold_len", qget(seg_end, 0) - qget(seg_start, 0) + 1, 11);
    chk("t1_release", qget(seg_end, 0), last_ival_cyc);
    chk("t1_ibeats", ibeats, 8);
    chk("t1_dbeats", dbeats, 0);
    chk("t1_fill_data", bad_fill, 0);
    chk("t1_proto", proto_err, 0);

    // All three requests together from reset
    do_reset();
    bus.dcache_addr = 16'h2345; bus.icache_addr = 16'h0400;
    bus.dcache_wr_addr = 16'h0100; bus.dcache_wr_data = 16'h5555;
    bus.dcache_req = 1'b1; bus.icache_req = 1'b1; bus.dcache_wr_req = 1'b1; c0 = cyc;
    run_idle(120, "t2");
    chk("t2_segs", seg_own.size(), 3);
    chk("t2_own0_d", qget(seg_own, 0), 2);
    chk("t2_own1_i", qget(seg_own, 1), 1);
    chk("t2_own2_w", qget(seg_own, 2), 3);
    chk("t2_start", qget(seg_start, 0), c0 + 1);
    chk("t2_gap1", qget(seg_start, 1) - qget(seg_end, 0), 2);
    chk("t2_gap2", qget(seg_start, 2) - qget(seg_end, 1), 2);
    chk("t2_wlen", qget(seg_end, 2) - qget(seg_start, 2), 0);
    chk("t2_d_first_addr", (iss_addr.size() > 0) ? 64'(iss_addr[0]) : 64'hFFFF_FFFF, 64'h2340);
    chk("t2_ibeats", ibeats, 8);
    chk("t2_dbeats", dbeats, 8);
    chk("t2_wdata", wr_data_l, 16'h5555);
    chk("t2_fill_data", bad_fill, 0);
    chk("t2_proto", proto_err, 0);

    // Store while idle
    do_reset();
    bus.dcache_wr_addr = 16'h00A4; bus.dcache_wr_data = 16'hBEEF;
    bus.dcache_wr_req = 1'b1; c0 = cyc;
    run_idle(20, "t3");
    chk("t3_wr_cnt", wr_cnt, 1);
    chk("t3_wr_addr", wr_addr_l, 16'h00A4);
    chk("t3_wr_data", wr_data_l, 16'hBEEF);
    chk("t3_ack_cnt", ack_cnt, 1);
    chk("t3_wr_cycle", wr_cyc, c0 + 1);
    chk("t3_no_reads", iss_addr.size(), 0);
    chk("t3_proto", proto_err, 0);

    // Store requested during a D-fill
    do_reset();
    bus.dcache_addr = 16'h4560; bus.dcache_req = 1'b1;
    repeat (4) step();
    bus.dcache_wr_addr = 16'h0010; bus.dcache_wr_data = 16'h1111; bus.dcache_wr_req = 1'b1;
    run_idle(60, "t4");
    chk("t4_segs", seg_own.size(), 2);
    chk("t4_own1_w", qget(seg_own, 1), 3);
    chk("t4_wr_after_fill", wr_cyc, qget(seg_end, 0) + 2);
    chk("t4_wr_cnt", wr_cnt, 1);
    chk("t4_ack_cnt", ack_cnt, 1);
    chk("t4_dbeats", dbeats, 8);
    chk("t4_proto", proto_err, 0);

    // Asynchronous reset after 3 D-fill beats
    do_reset();
    bus.dcache_addr = 16'h7770; bus.dcache_req = 1'b1;
    n = 0;
    while (dbeats < 3 && n < 30) begin
      step();
      n++;
    end
    chk("t5_three_beats", dbeats, 3);
    #2 rst = 1'b1;
    #1 chk("t5_async_outs", outs(), 64'd0);
    bus.dcache_req = 1'b0;
    step();
    rst = 1'b0;
    stray = 0;
    repeat (6) step();
    chk("t5_no_dbeat", dbeats, 3);
    chk("t5_no_ibeat", ibeats, 0);
    chk("t5_stray_seen", 64'(stray > 0), 64'd1);
    chk("t5_idle_grants", {bus.i_grant, bus.d_grant}, 2'b00);

    // Both fill requests held: grants alternate, mid-fill drop still completes
    do_reset();
    i_auto = 1'b0; d_auto = 1'b0;
    bus.icache_addr = 16'h1100; bus.dcache_addr = 16'h2200;
    bus.icache_req = 1'b1; bus.dcache_req = 1'b1;
    n = 0;
    while (seg_own.size() < 4 && n < 100) begin
      step();
      n++;
    end
    bus.icache_req = 1'b0; bus.dcache_req = 1'b0;
    run_idle(60, "t6");
    chk("t6_segs", seg_own.size(), 4);
    chk("t6_own0_d", qget(seg_own, 0), 2);
    chk("t6_own1_i", qget(seg_own, 1), 1);
    chk("t6_own2_d", qget(seg_own, 2), 2);
    chk("t6_own3_i", qget(seg_own, 3), 1);
    chk("t6_gap", qget(seg_start, 2) - qget(seg_end, 1), 2);
    chk("t6_ibeats", ibeats, 16);
    chk("t6_dbeats", dbeats, 16);
    chk("t6_fill_data", bad_fill, 0);
    chk("t6_proto", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sits between the I-cache and D-cache fill FSMs and the single shared multi-cycle main memory. It grants memory to one requester at a time: I-fill, D-fill or D-side write-through store. For a fill it issues the 8 word reads of the 16-byte block back-to-back and returns each data beat, with its valid strobe, to the owning fill FSM. It releases the grant after the 8th beat returns.

## Interface
Parameters:
- BEATS, 8: words per cache block; fixes the 3-bit issue and return counters.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- icache_req  in  1  I-cache fill FSM busy (miss pending); level, held until its 8 beats are received
- icache_addr  in  16  I-cache miss address; only [15:4] used
- dcache_req  in  1  D-cache fill FSM busy; level
- dcache_addr  in  16  D-cache miss address; only [15:4] used
- dcache_wr_req  in  1  write-through store pending; level, held until dcache_wr_ack
- dcache_wr_addr  in  16  store word address
- dcache_wr_data  in  16  store data
- mem_enable  out  1  memory request strobe
- mem_wr  out  1  1 = write, 0 = read; valid only with mem_enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_data_valid  in  1  memory read beat valid
- mem_rdata  in  16  memory read data
- icache_data_valid  out  1  beat for I-cache fill FSM
- dcache_data_valid  out  1  beat for D-cache fill FSM
- fill_data  out  16  mem_rdata passed through to both caches, combinational
- dcache_wr_ack  out  1  one-cycle pulse when the store is issued
- i_grant, d_grant  out  1  current owner; usable as a stall qualifier

## Operation
- States: IDLE, IFILL, DFILL, DWRITE; encoded state, dff-based registers.
- IDLE arbitration, one decision per cycle:
  - Fixed priority is DFILL > DWRITE > IFILL.
  - Override: if a 1-bit last_d flag is set and icache_req=1, IFILL wins.
  - last_d is set when a DFILL or DWRITE completes and cleared when an IFILL completes.
- On entry to a fill, latch base = addr[15:4] of the winner. Clear issue_cnt and ret_cnt to 0.
- Issue phase in fill states, for issue_cnt = 0..7:
  - mem_enable=1, mem_wr=0, mem_addr={base, issue_cnt, 1'b0}.
  - issue_cnt increments each cycle.
  - After the 8th issue (issue_cnt wrapped), a done flag holds mem_enable=0.
- Return phase, overlapping the issue phase:
  - Each mem_data_valid increments ret_cnt.
  - mem_data_valid is forwarded to the owner's valid output only; the other cache's valid stays 0.
  - mem_data_valid seen in IDLE or DWRITE is ignored and forwarded to no one.
- Fill completion: on the 8th valid (ret_cnt=7 and valid), next state is IDLE.
- DWRITE lasts one cycle:
  - mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data, dcache_wr_ack=1.
  - Next state is IDLE.
- Requests arriving while busy are not lost: they are level signals, sampled again in IDLE.
- If the owner's req drops mid-fill, that is a protocol error. The arbiter still completes all 8 returns to keep memory in sync.
- Outputs are 0 when not driven: mem_addr, mem_wdata, all valids.

## Timing
- Reset value of every output is 0; state=IDLE, counters=0, last_d=0.
- Reset mid-fill: return to IDLE immediately (async). Beats still in flight from memory are dropped.
- Grant latency: req seen in IDLE at edge N means grant=1 and the first read issued in cycle N+1.
- A fill holds the grant from the first issue through the cycle of the 8th valid. With a 4-cycle memory this is 4+8-1 = 11 cycles minimum.
- IDLE lasts at least 1 cycle between owners, so there is no back-to-back grant.
- A store costs 2 cycles: the IDLE decision cycle plus the DWRITE cycle.
- Counter wrap: issue_cnt 7→0 sets the done flag; ret_cnt 7→0 coincides with the exit to IDLE.
- Simultaneous events:
  - Arbitration is decided only in IDLE.
  - mem_data_valid in the same cycle as the final issue is counted normally.

## Test plan
- Single I-miss, icache_req=1, addr 0x1234: mem_addr issues 0x1230,0x1232,…,0x123E in 8 consecutive cycles. icache_data_valid pulses 8 times, dcache_data_valid=0, and i_grant drops the cycle after the 8th beat.
- icache_req, dcache_req and dcache_wr_req all asserted in the same cycle from reset: order is DFILL, then IFILL (last_d override), then DWRITE. Each starts exactly 1 IDLE cycle after the previous one ends.
- Store 0xBEEF to 0x00A4 while idle: one cycle with mem_enable=1, mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, dcache_wr_ack=1. No other mem_enable is seen.
- Store requested mid-D-fill: dcache_wr_ack stays 0 until the fill completes, then pulses; no memory write occurs during the fill.
- rst asserted asynchronously after 3 D-fill beats: all outputs are 0 before the next edge. A stray mem_data_valid after reset produces no cache valid.
- Continuous dcache_req with icache_req held: grants alternate D, I, D.
